// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures 16-bit ADC samples from the WM8731 and
// streams them to SRAM with an incrementing word address, under start/pause/stop control.
module aud_recorder #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF,
  parameter int                SAMPLE_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_init_done,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_lrc,
  input  logic                i_adcdat,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_we,
  output logic                o_busy,
  output logic                o_full,
  output logic [ADDR_W:0]     o_len
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SHIFT,
    STORE,
    PAUSED
  } state_t;

  state_t              state;
  logic                lrc_prev;
  logic                lrc_fall;
  logic                pause_pending;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] shift;

  assign lrc_fall = lrc_prev & ~i_lrc;

  // The sample word is presented on o_data with o_we during the STORE cycle;
  // the address advances on the following edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      lrc_prev      <= 1'b1;
      pause_pending <= 1'b0;
      bit_cnt       <= '0;
      shift         <= '0;
      o_addr        <= '0;
      o_data        <= '0;
      o_len         <= '0;
      o_we          <= 1'b0;
      o_busy        <= 1'b0;
      o_full        <= 1'b0;
    end else begin
      lrc_prev <= i_lrc;
      o_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && i_init_done && !i_stop) begin
            state  <= WAIT_FRAME;
            o_busy <= 1'b1;
            o_addr <= '0;
            o_len  <= '0;
            o_full <= 1'b0;
          end
        end

        WAIT_FRAME: begin
          if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_pause) begin
            state <= PAUSED;
          end else if (lrc_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end

        SHIFT: begin
          if (i_stop) begin
            state         <= IDLE;
            o_busy        <= 1'b0;
            pause_pending <= 1'b0;
          end else begin
            shift   <= {shift[SAMPLE_W-2:0], i_adcdat};
            bit_cnt <= bit_cnt + CNT_ONE;
            if (i_pause) begin
              pause_pending <= 1'b1;
            end
            if (bit_cnt == CNT_LAST) begin
              state  <= STORE;
              o_data <= {shift[SAMPLE_W-2:0], i_adcdat};
              o_we   <= 1'b1;
              o_len  <= o_len + LEN_ONE;
            end
          end
        end

        STORE: begin
          o_addr        <= o_addr + ADDR_ONE;
          pause_pending <= 1'b0;
          if (o_addr == MAX_ADDR) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_full <= 1'b1;
          end else if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (pause_pending || i_pause) begin
            state <= PAUSED;
          end else begin
            state <= WAIT_FRAME;
          end
        end

        PAUSED: begin
          if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_start && !i_pause) begin
            state <= WAIT_FRAME;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Downstream consumer of the codec configuration stage. Starts only after the I2C initializer reports finished (`i_init_done`).
- Deserialises 16-bit left-channel ADC samples from the WM8731 I2S stream (master mode, I2S format, 16-bit).
- Writes each sample to SRAM as a single-cycle write strobe with an incrementing address.
- Clocked by the codec BCLK. Recording is controlled by the top-level start/pause/stop commands.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- MAX_ADDR, 20'hFFFFF, last writable address; recording stops after the write to this address.
- SAMPLE_W, 16, bits captured per sample (MSB first).

Ports:
- i_clk  input  1  codec BCLK; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_init_done  input  1  level; high once codec configuration has completed.
- i_start  input  1  one-cycle pulse: begin new recording, or resume if paused.
- i_pause  input  1  one-cycle pulse: pause at the next sample boundary.
- i_stop  input  1  one-cycle pulse: abort immediately.
- i_lrc  input  1  ADCLRC from codec; 0 = left channel.
- i_adcdat  input  1  ADCDAT serial data from codec.
- o_addr  output  ADDR_W  SRAM write address.
- o_data  output  SAMPLE_W  captured sample; valid while o_we=1.
- o_we  output  1  one-cycle SRAM write strobe.
- o_busy  output  1  high in any state other than IDLE.
- o_full  output  1  sticky; set when MAX_ADDR has been written.
- o_len  output  ADDR_W+1  number of samples written since the last fresh start.

Behaviour:

Reset (i_rst=1 at a rising edge):
- State = IDLE.
- o_addr, o_data, o_len = 0; o_we, o_busy, o_full = 0.
- lrc_prev = 1, bit counter = 0, shift register = 0.
- Reset mid-sample discards the partial sample; no write is issued.

General:
- All outputs are registered.
- lrc_prev is registered every cycle in every state.
- Left-frame start detect: `lrc_fall = lrc_prev & ~i_lrc`.

States:
- IDLE:
  - i_start & i_init_done & ~i_stop -> WAIT_FRAME; clear o_addr, o_len, o_full.
  - i_start while i_init_done=0 is ignored.
- WAIT_FRAME: on lrc_fall -> SHIFT, bit counter = 0. This cycle is the I2S one-BCLK delay slot; ADCDAT is not sampled.
- SHIFT:
  - Each cycle: `shift = {shift[SAMPLE_W-2:0], i_adcdat}`, counter += 1.
  - When counter == SAMPLE_W-1, the capture completes this cycle -> STORE.
  - Total capture is exactly 16 cycles after the delay slot.
- STORE (1 cycle):
  - o_data = shift, o_we = 1, o_addr = current address, o_len += 1.
  - Next cycle: o_we = 0, o_addr += 1.
  - If the written address was MAX_ADDR: o_full = 1 -> IDLE.
  - Else if a pause is pending -> PAUSED.
  - Else -> WAIT_FRAME.
- PAUSED:
  - i_start -> WAIT_FRAME; address and length are kept.
  - i_stop -> IDLE.

Pause:
- i_pause received in WAIT_FRAME -> PAUSED immediately.
- i_pause received in SHIFT/STORE sets pause_pending; the current sample completes first.
- pause_pending is cleared on entry to PAUSED.

Stop:
- i_stop from any non-IDLE state -> IDLE next cycle.
- Partial sample is dropped; o_we never asserted for it.
- o_addr and o_len keep their last committed values for playback.

Priorities and ignored inputs:
- Simultaneous pulses: stop > pause > start.
- i_start while in WAIT_FRAME, SHIFT or STORE is ignored.

Right channel: i_lrc=1 frames are ignored. No rising-edge detection is performed.

Address wrap: none. After o_full, a new i_start in IDLE restarts from address 0 and clears o_full.

Test Plan:
1. Reset; i_init_done=1; i_start pulse; drive one I2S left frame with word 16'hA5C3 (MSB on 2nd BCLK after LRC falls) -> exactly 1 cycle of o_we=1 with o_addr=0, o_data=16'hA5C3, o_len=1; next cycle o_addr=1.
2. i_init_done=0 then i_start -> o_busy stays 0, no o_we. Raise i_init_done and pulse start -> recording begins.
3. Three frames 16'h0001, 16'h8000, 16'hFFFF; right-channel data = 16'h1234 -> writes at addresses 0, 1, 2 with those values only; 16'h1234 never written.
4. i_pause pulse at bit 5 of the 2nd sample -> 2nd sample still written (o_len=2), then PAUSED, no writes for 5 frames. i_start -> next write at o_addr=2.
5. i_stop pulse mid-SHIFT of the 3rd sample -> no 3rd write; o_busy=0 next cycle; o_len=2. Start+stop in the same cycle while in IDLE -> stays IDLE.
6. MAX_ADDR=3: record 5 frames -> writes at 0..3, then o_full=1, o_busy=0, no 5th write. i_start -> o_full=0, o_addr=0.
